// File: rtl/rc4_pkg.sv
// rtl/rc4_pkg.sv - shared RC4 types: byte type, KSA state encoding, S-box bounds
package rc4_pkg;

  typedef logic [7:0] byte_t;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    RD   = 3'd1,
    WAIT = 3'd2,
    CALC = 3'd3,
    REQ  = 3'd4,
    NEXT = 3'd5,
    DONE = 3'd6
  } ksa_state_t;

  localparam byte_t SBOX_LAST = 8'd255;

endpackage

// File: rtl/ksa_ctrl.sv
// rtl/ksa_ctrl.sv - RC4 key-scheduling loop controller issuing one swap request per index
// Optional macro KSA_SKIP_SELF_SWAP_EN: skip the swap request when i equals the new j.
module ksa_ctrl
  import rc4_pkg::*;
#(
  parameter int KEY_BYTES = 3,
  parameter int READ_LAT  = 2
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   start,
  input  logic [8*KEY_BYTES-1:0] secret_key,
  output logic                   busy,
  output logic                   done,
  output logic                   mem_sel,
  output logic [7:0]             mem_address,
  input  logic [7:0]             mem_rdata,
  output logic                   swap_req,
  output logic [7:0]             swap_i,
  output logic [7:0]             swap_j,
  input  logic                   swap_done
);

  localparam int KW = (KEY_BYTES > 1) ? $clog2(KEY_BYTES) : 1;
  localparam int CW = $clog2(READ_LAT + 1) + 1;
  localparam logic [KW-1:0] KEY_LAST  = KW'(KEY_BYTES - 1);
  localparam logic [CW-1:0] WAIT_LAST = CW'(READ_LAT - 1);

  ksa_state_t    state_q, state_d;
  byte_t         i_q, i_d;
  byte_t         j_q, j_d;
  byte_t         s_i_q, s_i_d;
  byte_t         swap_i_q, swap_i_d;
  byte_t         swap_j_q, swap_j_d;
  byte_t         mem_addr_q, mem_addr_d;
  logic [KW-1:0] k_q, k_d;
  logic [CW-1:0] cnt_q, cnt_d;
  byte_t         key_byte;
  byte_t         j_new;

  // Key byte 0 sits in the most significant byte of secret_key.
  always_comb begin
    key_byte = '0;
    for (int b = 0; b < KEY_BYTES; b++) begin
      if (k_q == KW'(b)) key_byte = secret_key[8*(KEY_BYTES-1-b) +: 8];
    end
  end

  assign j_new = j_q + s_i_q + key_byte;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= IDLE;
      i_q        <= '0;
      j_q        <= '0;
      s_i_q      <= '0;
      swap_i_q   <= '0;
      swap_j_q   <= '0;
      mem_addr_q <= '0;
      k_q        <= '0;
      cnt_q      <= '0;
    end else begin
      state_q    <= state_d;
      i_q        <= i_d;
      j_q        <= j_d;
      s_i_q      <= s_i_d;
      swap_i_q   <= swap_i_d;
      swap_j_q   <= swap_j_d;
      mem_addr_q <= mem_addr_d;
      k_q        <= k_d;
      cnt_q      <= cnt_d;
    end
  end

  // The read address is loaded on entry to RD so it is already on the RAM
  // port during RD; WAIT then spans exactly READ_LAT cycles.
  always_comb begin
    state_d    = state_q;
    i_d        = i_q;
    j_d        = j_q;
    s_i_d      = s_i_q;
    swap_i_d   = swap_i_q;
    swap_j_d   = swap_j_q;
    mem_addr_d = mem_addr_q;
    k_d        = k_q;
    cnt_d      = cnt_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d    = RD;
          i_d        = '0;
          j_d        = '0;
          k_d        = '0;
          mem_addr_d = '0;
        end
      end
      RD: begin
        cnt_d   = '0;
        state_d = WAIT;
      end
      WAIT: begin
        if (cnt_q == WAIT_LAST) begin
          s_i_d   = mem_rdata;
          state_d = CALC;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      CALC: begin
        j_d      = j_new;
        swap_i_d = i_q;
        swap_j_d = j_new;
`ifdef KSA_SKIP_SELF_SWAP_EN
        state_d  = (j_new == i_q) ? NEXT : REQ;
`else
        state_d  = REQ;
`endif
      end
      REQ: begin
        if (swap_done) state_d = NEXT;
      end
      NEXT: begin
        k_d = (k_q == KEY_LAST) ? '0 : k_q + KW'(1);
        if (i_q == SBOX_LAST) begin
          state_d = DONE;
        end else begin
          i_d        = i_q + 8'd1;
          mem_addr_d = i_q + 8'd1;
          state_d    = RD;
        end
      end
      DONE: state_d = IDLE;
      default: begin
        state_d    = IDLE;
        i_d        = '0;
        j_d        = '0;
        s_i_d      = '0;
        swap_i_d   = '0;
        swap_j_d   = '0;
        mem_addr_d = '0;
        k_d        = '0;
        cnt_d      = '0;
      end
    endcase
  end

  // Outputs decode straight from the state register so reset drops them at once.
  always_comb begin
    busy     = 1'b0;
    done     = 1'b0;
    swap_req = 1'b0;
    mem_sel  = 1'b1;
    case (state_q)
      RD, WAIT, CALC, NEXT: busy = 1'b1;
      REQ: begin
        busy     = 1'b1;
        swap_req = 1'b1;
        mem_sel  = 1'b0;
      end
      DONE: begin
        busy = 1'b1;
        done = 1'b1;
      end
      default: ;
    endcase
  end

  assign mem_address = mem_addr_q;
  assign swap_i      = swap_i_q;
  assign swap_j      = swap_j_q;

endmodule

// File: tb/tb_ksa_ctrl.sv
// tb/tb_ksa_ctrl.sv - self-checking bench for ksa_ctrl with RAM, swap engine and KSA reference model
module tb_ksa_ctrl;
  import rc4_pkg::*;

  localparam int KB = 3;

  logic          clk = 1'b0;
  logic          reset_n = 1'b1;
  logic          start = 1'b0;
  logic [8*KB-1:0] secret_key = '0;
  logic          busy, done, mem_sel, swap_req;
  logic          swap_done = 1'b0;
  logic [7:0]    mem_address, swap_i, swap_j;
  logic [7:0]    mem_rdata = 8'd0;

  always #5 clk = ~clk;

  ksa_ctrl #(.KEY_BYTES(KB), .READ_LAT(2)) dut (
    .clk(clk), .reset_n(reset_n), .start(start), .secret_key(secret_key),
    .busy(busy), .done(done), .mem_sel(mem_sel), .mem_address(mem_address),
    .mem_rdata(mem_rdata), .swap_req(swap_req), .swap_i(swap_i), .swap_j(swap_j),
    .swap_done(swap_done)
  );

  int n_assert = 0;
  int n_fail = 0;

  byte_t init_sbox [256];
  byte_t sbox [256];
  byte_t obs_i [512];
  byte_t obs_j [512];
  byte_t exp_i [256];
  byte_t exp_j [256];
  byte_t exp_sbox [256];
  int    exp_n = 0;
  byte_t r1 = 8'd0;
  byte_t tmp;
  int fill_tok = 0, fill_seen = 0, spur_tok = 0, spur_seen = 0;
  int swap_delay = 0, eng_cnt = 0, obs_n = 0;

  // RAM with two-cycle read latency plus the swap engine acting on the same array.
  always @(posedge clk) begin
    swap_done <= 1'b0;
    if (fill_tok != fill_seen) begin
      for (int a = 0; a < 256; a++) sbox[a] = init_sbox[a];
      obs_n = 0;
      fill_seen = fill_tok;
    end
    r1 <= sbox[mem_address];
    mem_rdata <= r1;
    if (spur_tok != spur_seen) begin
      swap_done <= 1'b1;
      spur_seen = spur_tok;
    end
    if (!reset_n) begin
      eng_cnt = 0;
    end else if (swap_req && !swap_done) begin
      if (eng_cnt >= swap_delay) begin
        swap_done <= 1'b1;
        tmp = sbox[swap_i];
        sbox[swap_i] = sbox[swap_j];
        sbox[swap_j] = tmp;
        if (obs_n < 512) begin
          obs_i[obs_n] = swap_i;
          obs_j[obs_n] = swap_j;
        end
        obs_n++;
        eng_cnt = 0;
      end else begin
        eng_cnt++;
      end
    end
  end

  int mon_seen = 0;
  int req_pulses = 0, done_cnt = 0, v_stable = 0, v_memsel = 0, v_retrig = 0, v_x = 0;
  logic  p_req = 1'b0, p_sw = 1'b0;
  byte_t p_i = 8'd0, p_j = 8'd0;

  always @(negedge clk) begin
    if (fill_tok != mon_seen) begin
      req_pulses = 0; done_cnt = 0; v_stable = 0; v_memsel = 0; v_retrig = 0; v_x = 0;
      mon_seen = fill_tok;
    end
    if (swap_req && !p_req) req_pulses++;
    if (swap_req && p_req && (swap_i !== p_i || swap_j !== p_j)) v_stable++;
    if (mem_sel !== ~swap_req) v_memsel++;
    if (p_sw && swap_req) v_retrig++;
    if ($isunknown({swap_i, swap_j, mem_address, busy, done, swap_req, mem_sel})) v_x++;
    if (done) done_cnt++;
    p_req = swap_req; p_i = swap_i; p_j = swap_j; p_sw = swap_done;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] expv);
    n_assert++;
    assert (got === expv) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, expv);
    end
  endtask

  // Plain RC4 key schedule over the initial S-box contents.
  task automatic model(input logic [8*KB-1:0] key);
    byte_t s [256];
    byte_t j, t, kb;
    bit skip;
    j = 8'd0;
    exp_n = 0;
    for (int a = 0; a < 256; a++) s[a] = init_sbox[a];
    for (int i = 0; i < 256; i++) begin
      kb = byte_t'((key >> (8 * (KB - 1 - (i % KB)))) & 24'hFF);
      j = j + s[i] + kb;
      skip = 1'b0;
`ifdef KSA_SKIP_SELF_SWAP_EN
      skip = (j == byte_t'(i));
`endif
      if (!skip) begin
        exp_i[exp_n] = byte_t'(i);
        exp_j[exp_n] = j;
        exp_n++;
      end
      t = s[i]; s[i] = s[j]; s[j] = t;
    end
    for (int a = 0; a < 256; a++) exp_sbox[a] = s[a];
  endtask

  task automatic run_pass(input string tag, input logic [8*KB-1:0] key, input int dly,
                          input bit inject, input bit abort);
    bit got_done, did_start, did_spur, last_req;
    int mism;
    secret_key = key;
    swap_delay = dly;
    fill_tok++;
    model(key);
    @(negedge clk);
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check({tag, "_busy_after_start"}, 32'(busy), 32'd1);
    got_done = 1'b0; did_start = 1'b0; did_spur = 1'b0; last_req = 1'b0;
    for (int cyc = 0; cyc < 20000 && !got_done; cyc++) begin
      @(negedge clk);
      if (abort && swap_req && swap_i == 8'd100) begin
        #2 reset_n = 1'b0;
        #1;
        check({tag, "_rst_swap_req"}, 32'(swap_req), 32'd0);
        check({tag, "_rst_busy"}, 32'(busy), 32'd0);
        check({tag, "_rst_done"}, 32'(done), 32'd0);
        check({tag, "_rst_mem_sel"}, 32'(mem_sel), 32'd1);
        @(negedge clk);
        reset_n = 1'b1;
        return;
      end
      if (inject && !did_start && swap_req && swap_i == 8'd50) begin
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        did_start = 1'b1;
      end
      if (inject && !did_spur && !swap_req && last_req && swap_i == 8'd60) begin
        spur_tok++;
        did_spur = 1'b1;
      end
      last_req = swap_req;
      if (done) begin
        got_done = 1'b1;
        check({tag, "_swaps_before_done"}, 32'(obs_n), 32'(exp_n));
      end
    end
    check({tag, "_done_seen"}, 32'(got_done), 32'd1);
    @(negedge clk);
    @(negedge clk);
    check({tag, "_done_pulses"}, 32'(done_cnt), 32'd1);
    check({tag, "_busy_low"}, 32'(busy), 32'd0);
    check({tag, "_req_pulses"}, 32'(req_pulses), 32'(exp_n));
    check({tag, "_viol_stable"}, 32'(v_stable), 32'd0);
    check({tag, "_viol_mem_sel"}, 32'(v_memsel), 32'd0);
    check({tag, "_viol_retrigger"}, 32'(v_retrig), 32'd0);
    check({tag, "_viol_x"}, 32'(v_x), 32'd0);
    check({tag, "_final_swap_i"}, 32'(swap_i), 32'd255);
    for (int k = 0; k < 3 && k < exp_n; k++) begin
      check($sformatf("%s_pair%0d_i", tag, k), 32'(obs_i[k]), 32'(exp_i[k]));
      check($sformatf("%s_pair%0d_j", tag, k), 32'(obs_j[k]), 32'(exp_j[k]));
    end
    mism = 0;
    for (int k = 0; k < exp_n && k < 512; k++)
      if (obs_i[k] !== exp_i[k] || obs_j[k] !== exp_j[k]) mism++;
    check({tag, "_pair_mismatches"}, 32'(mism), 32'd0);
    mism = 0;
    for (int a = 0; a < 256; a++) if (sbox[a] !== exp_sbox[a]) mism++;
    check({tag, "_sbox_mismatches"}, 32'(mism), 32'd0);
  endtask

  initial begin
    #1 reset_n = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_busy", 32'(busy), 32'd0);
    check("reset_done", 32'(done), 32'd0);
    check("reset_swap_req", 32'(swap_req), 32'd0);
    check("reset_mem_sel", 32'(mem_sel), 32'd1);
    check("reset_mem_address", 32'(mem_address), 32'd0);
    check("reset_swap_ij", {16'd0, swap_i, swap_j}, 32'd0);
    reset_n = 1'b1;
    @(negedge clk);

    for (int a = 0; a < 256; a++) init_sbox[a] = byte_t'(a);
    run_pass("ident_k010203", 24'h010203, 0, 1'b0, 1'b0);
    check("ident_first_i0", 32'(obs_i[0]), 32'd0);
    check("ident_first_j0", 32'(obs_j[0]), 32'd1);
    check("ident_first_j1", 32'(obs_j[1]), 32'd3);
    check("ident_first_j2", 32'(obs_j[2]), 32'd8);

    run_pass("handshake_dly7", 24'h010203, 7, 1'b0, 1'b0);

    for (int a = 0; a < 256; a++) init_sbox[a] = 8'hFF;
    run_pass("wrap_ff", 24'hFFFFFF, int'($urandom_range(0, 3)), 1'b0, 1'b0);

    for (int a = 0; a < 256; a++) init_sbox[a] = byte_t'($urandom);
    run_pass("rand_inject", 24'($urandom), int'($urandom_range(0, 4)), 1'b1, 1'b0);

    for (int a = 0; a < 256; a++) init_sbox[a] = byte_t'(a);
    run_pass("abort_i100", 24'($urandom), 2, 1'b0, 1'b1);

    run_pass("restart_k0", 24'h000000, 1, 1'b0, 1'b0);
`ifdef KSA_SKIP_SELF_SWAP_EN
    check("skip_first_i", 32'(obs_i[0]), 32'd2);
    check("skip_first_j", 32'(obs_j[0]), 32'd3);
`else
    check("noskip_first_j", 32'(obs_j[0]), 32'd0);
    check("noskip_second_j", 32'(obs_j[1]), 32'd1);
`endif

    run_pass("rand_key", 24'($urandom), int'($urandom_range(0, 5)), 1'b0, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/ksa_ctrl.md
Name: ksa_ctrl

Overview:
RC4 key-scheduling loop controller: walks i = 0..255, reads s[i] from the shared S-box RAM and computes j = j + s[i] + key[i mod KEY_BYTES].
It issues one swap request per iteration on the swap_req/swap_done handshake and waits for the swap engine to finish. It is the requesting end of that handshake, and sits between the top-level task FSM (start/done) and the swap engine.
It owns the S-box RAM port only while no swap is outstanding.

Parameters:
KEY_BYTES, 3, secret key length in bytes; key byte 0 is the most significant byte of secret_key.
READ_LAT, 2, cycles from mem_address presented to mem_rdata valid (synchronous RAM plus output register).

Ports:
clk  in  1  system clock, all state on rising edge
reset_n  in  1  asynchronous, active-low reset
start  in  1  begin KSA pass; sampled only in IDLE
secret_key  in  8*KEY_BYTES  key, held stable while busy
busy  out  1  high from the cycle after start is accepted until DONE
done  out  1  one-cycle pulse when the pass completes
mem_sel  out  1  1 = this block drives the RAM port; 0 = swap engine drives it
mem_address  out  8  RAM read address (reads only; this block never writes)
mem_rdata  in  8  RAM q
swap_req  out  1  swap request, level
swap_i  out  8  index i for the swap, stable while swap_req is high
swap_j  out  8  index j for the swap, stable while swap_req is high
swap_done  in  1  one-cycle completion pulse from the swap engine

Behaviour:
- Reset (async, any state): state=IDLE, i=0, j=0, busy=0, done=0, swap_req=0, swap_i=0, swap_j=0, mem_address=0, mem_sel=1.
- IDLE: on start=1 → RD, with i=0, j=0, busy=1. start while busy is ignored.
- RD: mem_address<=i, mem_sel=1, wait counter cleared → WAIT.
- WAIT: count READ_LAT cycles, then capture s_i<=mem_rdata → CALC.
- CALC: j<=j+s_i+key_byte[i mod KEY_BYTES]. Arithmetic is 8-bit, mod 256; carries dropped. Key index is a separate counter wrapping at KEY_BYTES-1 → 0, not a divider. → REQ.
- REQ: swap_req=1, swap_i=i, swap_j=j, mem_sel=0. Hold all three until swap_done is sampled 1. On that edge: swap_req<=0, mem_sel<=1 → NEXT.
  - swap_req is low in the cycle after swap_done, so the engine does not re-trigger.
- swap_done while not in REQ is ignored.
- NEXT: if i==255 → DONE, else i<=i+1 → RD.
- DONE: done=1 for exactly one cycle, busy<=0 → IDLE. i and j keep their final values; both clear on the next start.
- Iteration latency with the default feature off: 1 (RD) + READ_LAT + 1 (CALC) + swap latency + 1 (NEXT) cycles.
- Exactly 256 swap requests per pass.
- Reset mid-swap: swap_req drops immediately. The swap engine is on the same reset and must return to its idle state.
- Illegal state encoding → IDLE, with outputs at reset values.

Optional Feature:
KSA_SKIP_SELF_SWAP_EN:
- When defined, CALC compares i with the new j. If equal, it goes straight to NEXT with no swap_req pulse (the swap is an identity). Final S-box contents are unchanged; pass count of swaps is ≤256.
- When undefined, a swap is requested every iteration, including i==j.

Decomposition:
- Package rc4_pkg holds:
  - typedef byte_t (logic [7:0]);
  - state enum ksa_state_t {IDLE, RD, WAIT, CALC, REQ, NEXT, DONE};
  - constant SBOX_LAST = 8'd255.
  - Shared with the swap engine and the init/decrypt FSMs.
- No sub-module: key-byte selection and the wait counter are inline.

Test Plan:
- Identity S-box, key 0x010203: first swaps (i,j) = (0,1), (1,3), (2,8). Exactly 256 swap_req pulses. done pulses once, busy falls with it.
- Handshake: swap engine model delays swap_done 7 cycles. swap_req, swap_i and swap_j stay stable throughout; swap_req is 0 the cycle after swap_done; mem_sel is 0 only while swap_req=1.
- Wrap: S-box filled with 0xFF, key 0xFFFFFF. j wraps mod 256 with no X. Final i=255; done asserted after the i=255 swap.
- Reset: assert reset_n=0 during REQ at i=100. swap_req, busy and done drop asynchronously, mem_sel=1. A new start restarts at i=0, j=0.
- start pulsed while busy at i=50: ignored, and the pass still issues 256 swaps. A spurious swap_done in RD has no effect.
- KSA_SKIP_SELF_SWAP_EN defined, identity S-box, key 0x000000: no request at i=0 (j=0) or i=1 (j=1); first swap_req is (2,3). Final S-box matches a golden model.
